// File: rtl/float_types_pkg.sv
// Shared FPU add/sub pipeline types: unpacked operand, classification status
// and the alignment stage's state encoding.
package float_types_pkg;

  localparam int FP_MANT_W = 24;
  localparam int FP_EXP_W  = 8;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    OK_state   = 2'd0,
    ZERO_res   = 2'd1,
    NAN_or_INF = 2'd2
  } num_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } align_state_t;

endpackage

// File: rtl/sticky_shifter.sv
// Combinational right shift with every bit shifted out OR'd into bit 0 (sticky).
module sticky_shifter #(
  parameter int W  = 27,
  parameter int SW = 8
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] sh,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mask;
  logic         lost;

  always_comb begin
    mask = ~({W{1'b1}} << sh);
    lost = |(din & mask);
    dout = (din >> sh) | {{(W-1){1'b0}}, lost};
  end

endmodule

// File: rtl/align_stage.sv
// FPU add/sub alignment stage: orders operands by magnitude and right-aligns
// the smaller mantissa (G/R/S appended) using an iterative sticky shifter.
module align_stage
  import float_types_pkg::*;
#(
  parameter int MANT_W     = FP_MANT_W,
  parameter int EXP_W      = FP_EXP_W,
  parameter int SHIFT_STEP = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  float_point_num      a_i,
  input  float_point_num      b_i,
  input  num_status_t         status_i,
  output logic                valid_o,
  input  logic                ready_i,
  output float_point_num      big_o,
  output logic                small_sign_o,
  output logic [MANT_W+2:0]   small_mant_o,
  output logic                swap_o,
  output num_status_t         status_o,
  output logic                busy_o
);

  localparam int WW = MANT_W + 3;
  localparam logic [EXP_W-1:0] FULL_SH = EXP_W'(WW);
  localparam logic [EXP_W-1:0] STEP    = EXP_W'(SHIFT_STEP);

  align_state_t     state;
  logic [EXP_W-1:0] rem;

  // operand ordering; ties keep A as the big operand
  logic             swp;
  float_point_num   nbig, nsmall;
  logic [EXP_W-1:0] diff;
  logic [WW-1:0]    small_ext;

  always_comb begin
    swp       = {b_i.exp, b_i.mant} > {a_i.exp, a_i.mant};
    nbig      = swp ? b_i : a_i;
    nsmall    = swp ? a_i : b_i;
    diff      = nbig.exp - nsmall.exp;
    small_ext = {nsmall.mant, 3'b000};
  end

  logic [EXP_W-1:0] step_s;
  logic [WW-1:0]    sh_out;

  assign step_s = (rem < STEP) ? rem : STEP;

  sticky_shifter #(.W(WW), .SW(EXP_W)) u_shift (
    .din  (small_mant_o),
    .sh   (step_s),
    .dout (sh_out)
  );

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      rem          <= '0;
      valid_o      <= 1'b0;
      big_o        <= '0;
      small_sign_o <= 1'b0;
      small_mant_o <= '0;
      swap_o       <= 1'b0;
      status_o     <= OK_state;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          big_o        <= nbig;
          small_sign_o <= nsmall.sign;
          swap_o       <= swp;
          status_o     <= status_i;
          rem          <= diff;
          if (status_i != OK_state || diff == '0) begin
            small_mant_o <= small_ext;
            valid_o      <= 1'b1;
            state        <= HOLD;
          end else if (diff >= FULL_SH) begin
            // whole mantissa falls off the end: only sticky survives
            small_mant_o <= WW'(|nsmall.mant);
            valid_o      <= 1'b1;
            state        <= HOLD;
          end else begin
            small_mant_o <= small_ext;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          small_mant_o <= sh_out;
          rem          <= rem - step_s;
          if (rem == step_s) begin
            valid_o <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: if (ready_i) begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_align_stage.sv
// Directed bench for align_stage: ordering, alignment/sticky, latency,
// backpressure and asynchronous reset mid-operation.
module tb_align_stage;
  import float_types_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  float_point_num a_i = '0;
  float_point_num b_i = '0;
  num_status_t    status_i = OK_state;
  logic           valid_o;
  logic           ready_i = 1'b0;
  float_point_num big_o;
  logic           small_sign_o;
  logic [26:0]    small_mant_o;
  logic           swap_o;
  num_status_t    status_o;
  logic           busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  align_stage #(.MANT_W(24), .EXP_W(8), .SHIFT_STEP(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .status_i(status_i), .valid_o(valid_o),
    .ready_i(ready_i), .big_o(big_o), .small_sign_o(small_sign_o),
    .small_mant_o(small_mant_o), .swap_o(swap_o), .status_o(status_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic float_point_num fp(input logic s, input logic [7:0] e, input logic [23:0] m);
    float_point_num f;
    f.sign = s; f.exp = e; f.mant = m;
    return f;
  endfunction

  // Drive one operation; lat = edges from the accept edge (inclusive) until valid_o, -1 on timeout.
  task automatic run_op(input float_point_num a, input float_point_num b, input num_status_t st,
                        output int lat);
    @(negedge clk);
    a_i = a; b_i = b; status_i = st; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid_o) lat = -1;
  endtask

  task automatic finish_op();
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0) $display("FAIL reset_mant got %h want 0", small_mant_o); else pass_cnt++;
    total_cnt++; if (status_o !== OK_state) $display("FAIL reset_status got %0d want 0", status_o); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", ready_o); else pass_cnt++;
  endtask

  task automatic test_equal();
    int lat;
    run_op(fp(0, 127, 24'h800000), fp(0, 127, 24'h800000), OK_state, lat);
    total_cnt++; if (lat !== 1) $display("FAIL eq_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (swap_o !== 1'b0) $display("FAIL eq_swap got %0b want 0", swap_o); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h4000000) $display("FAIL eq_mant got %h want 4000000", small_mant_o); else pass_cnt++;
    total_cnt++; if (big_o.exp !== 8'd127) $display("FAIL eq_bigexp got %0d want 127", big_o.exp); else pass_cnt++;
    finish_op();
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL eq_valid_drop got %0b want 0", valid_o); else pass_cnt++;
  endtask

  task automatic test_swap_same_exp();
    int lat;
    run_op(fp(1, 130, 24'h800000), fp(0, 130, 24'h900000), OK_state, lat);
    total_cnt++; if (lat !== 1) $display("FAIL sameexp_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (swap_o !== 1'b1) $display("FAIL sameexp_swap got %0b want 1", swap_o); else pass_cnt++;
    total_cnt++; if (small_sign_o !== 1'b1) $display("FAIL sameexp_sign got %0b want 1", small_sign_o); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h4000000) $display("FAIL sameexp_mant got %h want 4000000", small_mant_o); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_shift_multi();
    int lat;
    run_op(fp(0, 127, 24'h800000), fp(1, 137, 24'hC00000), OK_state, lat);
    total_cnt++; if (lat !== 3) $display("FAIL shift10_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (swap_o !== 1'b1) $display("FAIL shift10_swap got %0b want 1", swap_o); else pass_cnt++;
    total_cnt++; if (big_o !== fp(1, 137, 24'hC00000)) $display("FAIL shift10_big got %h want %h", big_o, fp(1, 137, 24'hC00000)); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0010000) $display("FAIL shift10_mant got %h want 0010000", small_mant_o); else pass_cnt++;
    total_cnt++; if (small_sign_o !== 1'b0) $display("FAIL shift10_sign got %0b want 0", small_sign_o); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_sticky();
    int lat;
    run_op(fp(0, 131, 24'h800000), fp(0, 127, 24'h800001), OK_state, lat);
    total_cnt++; if (lat !== 2) $display("FAIL sticky_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0400001) $display("FAIL sticky_mant got %h want 0400001", small_mant_o); else pass_cnt++;
    finish_op();
    // diff = 26: last in-range shift, 4 cycles of stepping
    run_op(fp(0, 153, 24'h800000), fp(0, 127, 24'hFFFFFF), OK_state, lat);
    total_cnt++; if (lat !== 5) $display("FAIL diff26_latency got %0d want 5", lat); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0000001) $display("FAIL diff26_mant got %h want 0000001", small_mant_o); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_collapse();
    int lat;
    run_op(fp(0, 157, 24'h800000), fp(0, 127, 24'h800000), OK_state, lat);
    total_cnt++; if (lat !== 1) $display("FAIL collapse_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0000001) $display("FAIL collapse_mant got %h want 0000001", small_mant_o); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_special();
    int lat;
    run_op(fp(0, 200, 24'h800000), fp(0, 10, 24'hABCDEF), NAN_or_INF, lat);
    total_cnt++; if (lat !== 1) $display("FAIL nan_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (status_o !== NAN_or_INF) $display("FAIL nan_status got %0d want 2", status_o); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h55E6F78) $display("FAIL nan_mant got %h want 55e6f78", small_mant_o); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(fp(0, 127, 24'h800000), fp(0, 125, 24'h800000), OK_state, lat);
    total_cnt++; if (lat !== 2) $display("FAIL bp_latency got %0d want 2", lat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_i = i[0];
      a_i = fp(1, 8'(40 + i), 24'hFFFFFF); b_i = fp(0, 8'd3, 24'h812345);
      @(posedge clk); #1;
      total_cnt++; if (valid_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL bp_hs_%0d got v=%0b r=%0b want v=1 r=0", i, valid_o, ready_o); else pass_cnt++;
      total_cnt++; if (small_mant_o !== 27'h1000000 || big_o !== fp(0, 127, 24'h800000)) $display("FAIL bp_data_%0d got %h/%h want 1000000/%h", i, small_mant_o, big_o, fp(0, 127, 24'h800000)); else pass_cnt++;
    end
    @(negedge clk); valid_i = 1'b0;
    finish_op();
    total_cnt++; if (valid_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL bp_release got v=%0b r=%0b want v=0 r=1", valid_o, ready_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    a_i = fp(0, 147, 24'h800000); b_i = fp(0, 127, 24'h800000); status_i = OK_state; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL rst_mid_busy_before got %0b want 1", busy_o); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rst_mid_async got v=%0b b=%0b want 0/0", valid_o, busy_o); else pass_cnt++;
    total_cnt++; if (small_mant_o !== 27'h0 || big_o !== '0) $display("FAIL rst_mid_data got %h/%h want 0/0", small_mant_o, big_o); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL rst_mid_release got r=%0b v=%0b want 1/0", ready_o, valid_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_swap_same_exp();
    test_shift_multi();
    test_sticky();
    test_collapse();
    test_special();
    test_backpressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/align_stage.md
Name: align_stage

Overview:
- Second FPU add/sub pipeline stage, directly downstream of the operand fetch stage.
- Takes two unpacked operands (hidden bit already restored) and their classification status.
- Orders the operands by magnitude and right-aligns the smaller mantissa to the larger exponent with guard/round/sticky bits, using an iterative multi-cycle shifter.
- Presents the result to the add/normalise stage over a valid/ready handshake.

Parameters:
- MANT_W, 24, mantissa width including hidden bit
- EXP_W, 8, exponent width
- SHIFT_STEP, 8, maximum right-shift applied per cycle (1..MANT_W+3)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- valid_i  in  1  upstream operands valid
- ready_o  out  1  stage can accept operands
- a_i  in  float_point_num  operand A (sign, exp, mant with hidden bit)
- b_i  in  float_point_num  operand B
- status_i  in  num_status_t  OK_state / ZERO_res / NAN_or_INF
- valid_o  out  1  aligned result valid
- ready_i  in  1  downstream accepts result
- big_o  out  float_point_num  larger-magnitude operand, unshifted
- small_sign_o  out  1  sign of smaller operand
- small_mant_o  out  MANT_W+3  aligned smaller mantissa: [MANT_W+2:3] mantissa, [2] guard, [1] round, [0] sticky
- swap_o  out  1  1 when B was the larger operand
- status_o  out  num_status_t  status_i carried through
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; valid_o=0, all data outputs 0, swap_o=0, status_o=OK_state, busy_o=0. ready_o=1 once state is IDLE.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, capture both operands.
  - Magnitude compare on {exp,mant}. Swap only if B is strictly greater; equal magnitudes keep A as big.
  - diff = big.exp - small.exp, computed unsigned in EXP_W bits.
  - Working register W = {small.mant, 3'b000}. Remaining count R = diff.
- Next state from IDLE:
  - status_i != OK_state: go to HOLD. No shift; small_mant_o = {small.mant,3'b0}.
  - diff == 0: go to HOLD.
  - diff >= MANT_W+3: go to HOLD with W = {0..0, |small.mant} (all bits collapse into sticky).
  - Otherwise: go to SHIFT.
- SHIFT:
  - Each cycle, s = min(SHIFT_STEP, R).
  - W <= (W >> s) with bit0 |= OR of the s bits shifted out, OR'd with the old bit0.
  - R <= R - s. When the updated R == 0, go to HOLD.
  - ready_o=0. valid_i is ignored.
- HOLD:
  - valid_o=1. All outputs stable while ready_i=0. ready_o=0.
  - On ready_i=1: go to IDLE; valid_o drops next cycle.
- Latency:
  - Accept edge to valid_o high is 1 cycle for the direct-to-HOLD cases.
  - Otherwise 1 + ceil(diff/SHIFT_STEP) cycles.
- Throughput: one operation in flight. The next accept happens no earlier than the cycle after the handshake; no bypass from HOLD to accept.
- ready_i is don't-care outside HOLD.
- Reset asserted mid-SHIFT or mid-HOLD: operation discarded, outputs return to reset values immediately.
- Outputs are registered; only ready_o and busy_o are decoded from state.

Decomposition:
- float_types_pkg holds: float_point_num (sign, exp[EXP_W-1:0], mant[MANT_W-1:0]), num_status_t with constants OK_state/ZERO_res/NAN_or_INF, and the align_state_t enum (IDLE/SHIFT/HOLD).
- The fetch stage's status output is widened to num_status_t.
- One natural sub-module: sticky_shifter, a combinational shift-by-s over MANT_W+3 bits with sticky OR, instantiated once inside SHIFT.

Test Plan:
- a=b={0,127,0x800000}, OK_state -> valid_o after 1 cycle; swap_o=0; small_mant_o=0x4000000; big_o.exp=127.
- a={0,127,0x800000}, b={1,137,0xC00000}, SHIFT_STEP=8 -> 2 SHIFT cycles, valid_o at accept+3; swap_o=1; big_o=b; small_mant_o=0x0010000; small_sign_o=0.
- a={0,131,0x800000}, b={0,127,0x800001} -> diff=4; small_mant_o=0x0400001 (sticky set from a lost 1); latency 2.
- a exp 157, b exp 127, b.mant=0x800000 -> diff=30 ≥27; small_mant_o=0x0000001; latency 1.
- status_i=NAN_or_INF, a exp 200, b exp 10 -> no SHIFT cycles; status_o=NAN_or_INF; small_mant_o={b.mant,3'b0}.
- Backpressure: hold ready_i=0 for 5 cycles in HOLD -> outputs constant, ready_o=0, valid_i pulses ignored. Then rst_ni=0 during a diff=20 SHIFT -> valid_o=0, busy_o=0 immediately, ready_o=1 after release.
